// File: rtl/dco_bank_enc.sv
// DCO capacitor-bank drive: slews the applied tuning word toward the requested word
// in bounded, paced steps and decodes it into row/column thermometer selects.
module dco_bank_enc #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4,
    parameter int MAX_STEP = 16,
    parameter int STEP_DIV = 4,
    parameter int RST_WORD = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tune_valid,
    input  logic [ROW_BITS+COL_BITS-1:0]    tune_word,
    output logic                            tune_ready,
    output logic [(1<<ROW_BITS)-1:0]        r_all,
    output logic [(1<<ROW_BITS)-1:0]        row,
    output logic [(1<<COL_BITS)-1:0]        col,
    output logic [ROW_BITS+COL_BITS-1:0]    cur_word,
    output logic                            busy,
    output logic                            done
);
    localparam int W     = ROW_BITS + COL_BITS;
    localparam int NR    = 1 << ROW_BITS;
    localparam int NC    = 1 << COL_BITS;
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [W-1:0]        RST_CUR  = RST_WORD[W-1:0];
    localparam logic [W-1:0]        STEP_U   = MAX_STEP[W-1:0];
    localparam logic signed [W:0]   STEP_S   = $signed({1'b0, STEP_U});
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STEP_DIV - 1);

    typedef enum logic {S_IDLE, S_SLEW} state_t;

    state_t                 r_state, w_state_nxt;
    logic [W-1:0]           r_cur, w_cur_nxt;
    logic [W-1:0]           r_tgt, w_tgt_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   r_done, w_done_nxt;
    logic signed [W:0]      w_diff;
    logic signed [W:0]      w_mag;

    // Cell r,c is on when r_all[r] | (row[r] & col[c]); enabled count equals cur.
    function automatic logic [2*NR+NC-1:0] decode(input logic [W-1:0] cur);
        logic [ROW_BITS-1:0] q;
        logic [COL_BITS-1:0] m;
        logic [NR-1:0]       ra;
        logic [NR-1:0]       rw;
        logic [NC-1:0]       cl;
        q = cur[W-1:COL_BITS];
        m = cur[COL_BITS-1:0];
        for (int i = 0; i < NR; i++) begin
            ra[i] = (i < int'(q));
            rw[i] = (i == int'(q));
        end
        for (int j = 0; j < NC; j++) begin
            cl[j] = (j < int'(m));
        end
        return {ra, rw, cl};
    endfunction

    // One extra bit keeps the signed distance exact over the whole word range.
    assign w_diff = $signed({1'b0, r_tgt}) - $signed({1'b0, r_cur});
    assign w_mag  = w_diff[W] ? -w_diff : w_diff;

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_tgt_nxt   = r_tgt;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tune_valid) begin
                    w_tgt_nxt   = tune_word;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SLEW;
                end
            end
            S_SLEW: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_mag <= STEP_S) begin
                        w_cur_nxt   = r_tgt;
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (w_diff[W]) begin
                        w_cur_nxt = r_cur - STEP_U;
                    end else begin
                        w_cur_nxt = r_cur + STEP_U;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Decode from the next-state word so selects line up with cur_word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_cur              <= RST_CUR;
            r_tgt              <= RST_CUR;
            r_cnt              <= '0;
            r_done             <= 1'b0;
            {r_all, row, col}  <= decode(RST_CUR);
        end else begin
            r_state            <= w_state_nxt;
            r_cur              <= w_cur_nxt;
            r_tgt              <= w_tgt_nxt;
            r_cnt              <= w_cnt_nxt;
            r_done             <= w_done_nxt;
            {r_all, row, col}  <= decode(w_cur_nxt);
        end
    end

    assign tune_ready = (r_state == S_IDLE);
    assign busy       = (r_state == S_SLEW);
    assign done       = r_done;
    assign cur_word   = r_cur;

endmodule

// File: tb/tb_dco_bank_enc.sv
// Directed bench for dco_bank_enc with default parameters (4x4 row/col bits, step 16, pace 4).
module tb_dco_bank_enc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tune_valid = 1'b0;
    logic [7:0]  tune_word = '0;
    logic        tune_ready;
    logic [15:0] r_all;
    logic [15:0] row;
    logic [15:0] col;
    logic [7:0]  cur_word;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int expq[32];

    dco_bank_enc dut (
        .clk        (clk),
        .rst        (rst),
        .tune_valid (tune_valid),
        .tune_word  (tune_word),
        .tune_ready (tune_ready),
        .r_all      (r_all),
        .row        (row),
        .col        (col),
        .cur_word   (cur_word),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Thermometer expectations from arithmetic, independent of the RTL loops.
    task automatic chk_decode(input string tag, input int w);
        int q, m;
        q = w / 16;
        m = w % 16;
        chk({tag, ".r_all"}, r_all, 64'((32'h1 << q) - 1));
        chk({tag, ".row"},   row,   64'(32'h1 << q));
        chk({tag, ".col"},   col,   64'((32'h1 << m) - 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tune_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic accept(input int w);
        tune_valid = 1'b1;
        tune_word  = 8'(w);
        tick();
        tune_valid = 1'b0;
        chk("acc.busy",  busy, 1);
        chk("acc.ready", tune_ready, 0);
    endtask

    // Follow n paced steps after an acceptance edge, checking every cycle.
    task automatic follow(input int n);
        int prev;
        prev = cur_word;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (c < 3) tick();
                else tick();
                if (c < 3) begin
                    chk("slew.hold", cur_word, 64'(prev));
                    chk("slew.busy", busy, 1);
                    chk("slew.nodone", done, 0);
                end else begin
                    chk("slew.cur", cur_word, 64'(expq[k]));
                    chk_decode("slew", expq[k]);
                    chk("slew.done", done, (k == n - 1) ? 1 : 0);
                    prev = expq[k];
                end
            end
        end
        chk("end.ready", tune_ready, 1);
        chk("end.busy", busy, 0);
    endtask

    initial begin
        do_reset();
        chk("rst.cur",   cur_word, 0);
        chk("rst.r_all", r_all, 16'h0000);
        chk("rst.row",   row,   16'h0001);
        chk("rst.col",   col,   16'h0000);
        chk("rst.ready", tune_ready, 1);
        chk("rst.busy",  busy, 0);
        chk("rst.done",  done, 0);

        // small word: single step
        accept(5);
        expq[0] = 5;
        follow(1);
        chk("w5.col", col, 16'h001F);
        chk("w5.row", row, 16'h0001);
        tick();
        chk("w5.done_once", done, 0);

        // 0 -> 100 after reset
        do_reset();
        accept(100);
        expq[0:6] = '{16, 32, 48, 64, 80, 96, 100};
        follow(7);
        chk("w100.r_all", r_all, 16'h003F);
        chk("w100.row",   row,   16'h0040);
        chk("w100.col",   col,   16'h000F);
        tick();
        chk("w100.done_once", done, 0);

        // 100 -> 17 downward
        accept(17);
        expq[0:5] = '{84, 68, 52, 36, 20, 17};
        follow(6);
        chk("w17.r_all", r_all, 16'h0001);
        chk("w17.row",   row,   16'h0002);
        chk("w17.col",   col,   16'h0001);
        tick();

        // 0 -> 255 full scale
        do_reset();
        accept(255);
        for (int k = 1; k <= 15; k++) expq[k-1] = 16 * k;
        expq[15] = 255;
        follow(16);
        chk("w255.r_all", r_all, 16'h7FFF);
        chk("w255.row",   row,   16'h8000);
        chk("w255.col",   col,   16'h7FFF);
        tick();

        // 0 -> 200 with a competing word held valid, then reset mid-slew
        do_reset();
        accept(200);
        tune_valid = 1'b1;
        tune_word  = 8'd50;
        for (int c = 0; c < 4; c++) tick();
        chk("ign.cur1", cur_word, 16);
        for (int c = 0; c < 4; c++) tick();
        chk("ign.cur2", cur_word, 32);
        chk("ign.busy", busy, 1);
        tick();
        tick();
        rst = 1'b1;
        tune_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("mrst.cur",   cur_word, 0);
        chk("mrst.busy",  busy, 0);
        chk("mrst.ready", tune_ready, 1);
        chk("mrst.done",  done, 0);
        chk("mrst.row",   row, 16'h0001);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("mrst.quiet", done | busy, 0);
        end

        // back-to-back accept in the done cycle
        accept(5);
        for (int c = 0; c < 4; c++) tick();
        chk("b2b.done",  done, 1);
        chk("b2b.ready", tune_ready, 1);
        chk("b2b.cur",   cur_word, 5);
        accept(40);
        chk("b2b.hold", cur_word, 5);
        expq[0:2] = '{21, 37, 40};
        follow(3);
        tick();
        chk("b2b.done_once", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
